// File: rtl/pipe_reg_stage.sv
// One register slot of pipe_reg_chain: valid bit plus payload, loaded when the
// chain's ready logic grants this stage.
module pipe_reg_stage #(
  parameter int DATA_WIDTH          = 32,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Flush,
  input  logic                  ld,
  input  logic                  src_vld,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  vld,
  output logic [DATA_WIDTH-1:0] data
);

  // Payload only moves with a real item, so a bubble leaves the old value in place.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      vld  <= 1'b0;
      data <= '0;
    end else if (Flush) begin
      vld <= 1'b0;
      if (CLEAR_DATA_ON_FLUSH) data <= '0;
    end else if (ld) begin
      vld <= src_vld;
      if (src_vld) data <= src_data;
    end
  end

endmodule

// File: rtl/pipe_reg_chain.sv
// Chain of DEPTH handshake register stages with same-cycle bubble collapse,
// synchronous flush and a registered occupancy count.
module pipe_reg_chain #(
  parameter int DATA_WIDTH          = 32,
  parameter int DEPTH               = 2,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b0,
  localparam int OCC_W              = $clog2(DEPTH + 1)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Flush,
  input  logic                  InValid,
  output logic                  InReady,
  input  logic [DATA_WIDTH-1:0] InData,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic [DATA_WIDTH-1:0] OutData,
  output logic [OCC_W-1:0]      Occupancy
);

  logic [DEPTH-1:0]      v;
  logic [DEPTH-1:0]      ld;
  logic [DEPTH-1:0]      src_v;
  logic [DATA_WIDTH-1:0] d [DEPTH];
  logic                  in_hs;
  logic                  out_hs;

  // Bit i is the valid bit offered to stage i: InValid for stage 0, v[i-1] otherwise.
  assign src_v = (v << 1) | DEPTH'(InValid);

  // Ready ripples from the output back to stage 0 so any hole lets the chain advance.
  always_comb begin
    logic mv;
    mv = v[DEPTH-1] & ~Flush & OutReady;
    ld = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ld[i] = ~v[i] | mv;
      mv    = src_v[i] & ld[i];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    if (g == 0) begin : g_first
      pipe_reg_stage #(
        .DATA_WIDTH          (DATA_WIDTH),
        .CLEAR_DATA_ON_FLUSH (CLEAR_DATA_ON_FLUSH)
      ) u_stage (
        .CLK      (CLK),
        .RST      (RST),
        .Flush    (Flush),
        .ld       (ld[g]),
        .src_vld  (src_v[g]),
        .src_data (InData),
        .vld      (v[g]),
        .data     (d[g])
      );
    end else begin : g_next
      pipe_reg_stage #(
        .DATA_WIDTH          (DATA_WIDTH),
        .CLEAR_DATA_ON_FLUSH (CLEAR_DATA_ON_FLUSH)
      ) u_stage (
        .CLK      (CLK),
        .RST      (RST),
        .Flush    (Flush),
        .ld       (ld[g]),
        .src_vld  (src_v[g]),
        .src_data (d[g-1]),
        .vld      (v[g]),
        .data     (d[g])
      );
    end
  end

  assign InReady  = ld[0] & ~Flush;
  assign OutValid = v[DEPTH-1] & ~Flush;
  assign OutData  = d[DEPTH-1];
  assign in_hs    = InValid & InReady;
  assign out_hs   = OutValid & OutReady;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      Occupancy <= '0;
    end else if (Flush) begin
      Occupancy <= '0;
    end else if (in_hs && !out_hs) begin
      Occupancy <= Occupancy + OCC_W'(1);
    end else if (out_hs && !in_hs) begin
      Occupancy <= Occupancy - OCC_W'(1);
    end
  end

endmodule
